// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-3 target that behaves like a serial configuration flash. It
//   understands wake-up (0xAB), deep power-down (0xB9) and READ (0x03 plus a
//   24-bit address), and serves read data from a byte-wide synchronous memory.
//
// Optional build macro: SPI_FLASH_RESPONDER_FAST_READ_EN
//   When defined, FAST READ (0x0B) is accepted. It takes an address, then 8
//   dummy clocks, then data. When undefined, 0x0B is an unsupported opcode.
//
// Ports
//   clock, reset_n          system clock, async active-low reset
//   spi_clk/cs_n/mosi       SPI inputs (asynchronous, synchronized here)
//   spi_miso, spi_miso_oe   serial data out, high-drive enable during data
//   mem_addr, mem_rd_en     memory read request (one-clock strobe)
//   mem_rdata               memory data, valid one clock after mem_rd_en
//   powered_down, busy      power state and wake-up timer status
//   cmd_valid, cmd_opcode   opcode-complete pulse and last opcode
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | chip select high, waiting for a frame
// S_OPCODE | shifting in the 8 opcode bits
// S_ADDR   | shifting in the 24 address bits
// S_DUMMY  | FAST READ dummy clocks (only with the fast-read macro)
// S_DATA   | shifting out memory bytes, address auto-increments
// S_IGNORE | frame rejected or finished decoding, wait for cs_n high
module spi_flash_responder #(
   parameter bit RESET_POWERED_DOWN = 1'b1,
   parameter int WAKE_CLOCKS        = 875,
   parameter bit MISO_IDLE          = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        spi_clk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic [23:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [7:0]  mem_rdata,
   output logic        powered_down,
   output logic        busy,
   output logic        cmd_valid,
   output logic [7:0]  cmd_opcode
);
   localparam int BW = (WAKE_CLOCKS > 1) ? $clog2(WAKE_CLOCKS + 1) : 1;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WAKE  = 8'hAB;
   localparam logic [7:0] OP_SLEEP = 8'hB9;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
   localparam logic [7:0] OP_FAST  = 8'h0B;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_OPCODE, S_ADDR, S_DATA, S_IGNORE
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      , S_DUMMY
`endif
   } state_t;

   typedef enum logic [1:0] {P_NONE, P_SLEEP, P_WAKE} pend_t;

   logic [1:0] clk_sync, cs_sync, mosi_sync;
   logic       clk_prev, cs_prev;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= 2'b11;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         clk_prev  <= 1'b1;
         cs_prev   <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], spi_clk};
         cs_sync   <= {cs_sync[0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         clk_prev  <= clk_sync[1];
         cs_prev   <= cs_sync[1];
      end
   end

   assign sclk_rise = clk_sync[1] & ~clk_prev;
   assign sclk_fall = ~clk_sync[1] & clk_prev;
   assign cs_fall   = ~cs_sync[1] & cs_prev;
   assign cs_rise   = cs_sync[1] & ~cs_prev;
   assign mosi_bit  = mosi_sync[1];

   state_t          state;
   pend_t           pend;
   logic [6:0]      op_sr;
   logic [22:0]     addr_sr;
   logic [7:0]      tx_sr;
   logic [4:0]      bit_cnt;
   logic [3:0]      frame_bits;   // rising edges in this frame, saturating
   logic            rd_req;
   logic            rd_dly;
   logic [BW-1:0]   busy_cnt;
   logic [7:0]      op_next;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
   logic            fast;
`endif

   assign op_next = {op_sr, mosi_bit};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         pend         <= P_NONE;
         op_sr        <= '0;
         addr_sr      <= '0;
         tx_sr        <= '0;
         bit_cnt      <= '0;
         frame_bits   <= '0;
         rd_req       <= 1'b0;
         rd_dly       <= 1'b0;
         busy_cnt     <= '0;
         spi_miso     <= MISO_IDLE;
         spi_miso_oe  <= 1'b0;
         mem_addr     <= '0;
         mem_rd_en    <= 1'b0;
         powered_down <= RESET_POWERED_DOWN;
         busy         <= 1'b0;
         cmd_valid    <= 1'b0;
         cmd_opcode   <= '0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
         fast         <= 1'b0;
`endif
      end else begin
         cmd_valid <= 1'b0;
         rd_req    <= 1'b0;
         mem_rd_en <= rd_req;
         rd_dly    <= mem_rd_en;

         if (busy) begin
            busy_cnt <= busy_cnt - BW'(1);
            if (busy_cnt == BW'(1)) busy <= 1'b0;
         end

         if (cs_rise) begin
            // End of frame wins over any byte completing in the same clock.
            state       <= S_IDLE;
            spi_miso_oe <= 1'b0;
            spi_miso    <= MISO_IDLE;
            rd_req      <= 1'b0;
            pend        <= P_NONE;
            if (frame_bits == 4'd8) begin
               if (pend == P_SLEEP) begin
                  powered_down <= 1'b1;
               end else if (pend == P_WAKE) begin
                  powered_down <= 1'b0;
                  busy         <= (WAKE_CLOCKS > 0);
                  busy_cnt     <= BW'(WAKE_CLOCKS);
               end
            end
         end else begin
            if (sclk_rise && frame_bits != 4'hF) frame_bits <= frame_bits + 4'd1;

            case (state)
               S_IDLE: begin
                  if (cs_fall) begin
                     state      <= S_OPCODE;
                     bit_cnt    <= '0;
                     frame_bits <= '0;
                     pend       <= P_NONE;
                  end
               end

               S_OPCODE: begin
                  if (sclk_rise) begin
                     op_sr   <= op_next[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt    <= '0;
                        cmd_valid  <= 1'b1;
                        cmd_opcode <= op_next;
                        state      <= S_IGNORE;
                        // Powered down: only wake-up survives, the rest drop.
                        if (op_next == OP_WAKE) begin
                           pend <= P_WAKE;
                        end else if (!powered_down) begin
                           if (op_next == OP_SLEEP) begin
                              pend <= P_SLEEP;
                           end else if (!busy && op_next == OP_READ) begin
                              state <= S_ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                              fast  <= 1'b0;
                           end else if (!busy && op_next == OP_FAST) begin
                              state <= S_ADDR;
                              fast  <= 1'b1;
`endif
                           end
                        end
                     end
                  end
               end

               S_ADDR: begin
                  if (sclk_rise) begin
                     addr_sr <= {addr_sr[21:0], mosi_bit};
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt  <= '0;
                        mem_addr <= {addr_sr, mosi_bit};
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                        if (fast) begin
                           state <= S_DUMMY;
                        end else begin
                           state       <= S_DATA;
                           spi_miso_oe <= 1'b1;
                           rd_req      <= 1'b1;
                        end
`else
                        state       <= S_DATA;
                        spi_miso_oe <= 1'b1;
                        rd_req      <= 1'b1;
`endif
                     end
                  end
               end

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
               S_DUMMY: begin
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt     <= '0;
                        state       <= S_DATA;
                        spi_miso_oe <= 1'b1;
                        rd_req      <= 1'b1;
                     end
                  end
               end
`endif

               S_DATA: begin
                  if (sclk_fall) begin
                     spi_miso <= tx_sr[7];
                     tx_sr    <= {tx_sr[6:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt  <= '0;
                        mem_addr <= mem_addr + 24'd1;
                        rd_req   <= 1'b1;
                     end
                  end
               end

               S_IGNORE: ;

               default: state <= S_IDLE;
            endcase
         end

         // The prefetched byte lands well before the next falling edge.
         if (rd_dly) tx_sr <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
   localparam int HALF = 80;   // SPI half period: 8 system clocks

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_clk = 1'b1;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;
   logic [23:0] mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_rdata = 8'h00;
   logic        powered_down;
   logic        busy;
   logic        cmd_valid;
   logic [7:0]  cmd_opcode;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_cmd[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_byte[$];
   int          exp_busy[$];

   spi_flash_responder dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .spi_clk      (spi_clk),
      .spi_cs_n     (spi_cs_n),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .spi_miso_oe  (spi_miso_oe),
      .mem_addr     (mem_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_rdata    (mem_rdata),
      .powered_down (powered_down),
      .busy         (busy),
      .cmd_valid    (cmd_valid),
      .cmd_opcode   (cmd_opcode)
   );

   always #5 clock = ~clock;

   // Memory returns addr[7:0] ^ 0x5A one clock after the strobe.
   always @(posedge clock) if (mem_rd_en) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] got);
      total++;
      bad++;
      $display("FAIL %s got=%h exp=none", name, got);
   endtask

   // Monitor: opcode pulses, memory strobes and busy pulse length.
   int busy_run = 0;
   always @(negedge clock) begin
      if (reset_n) begin
         if (cmd_valid) begin
            if (exp_cmd.size() == 0) unexpected("cmd_unexpected", {24'h0, cmd_opcode});
            else check("cmd_opcode", {24'h0, cmd_opcode}, exp_cmd.pop_front());
         end
         if (mem_rd_en) begin
            if (exp_addr.size() == 0) unexpected("rd_unexpected", {8'h0, mem_addr});
            else check("mem_addr", {8'h0, mem_addr}, exp_addr.pop_front());
         end
         if (busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            if (exp_busy.size() == 0) unexpected("busy_unexpected", busy_run);
            else check("busy_len", busy_run, exp_busy.pop_front());
            busy_run = 0;
         end
      end
   end

   // Monitor: collect MISO bytes while the responder drives them.
   logic [7:0] mon_sr = 8'h00;
   int         mon_n  = 0;
   always @(posedge spi_clk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         mon_n = 0;
      end else if (spi_miso_oe) begin
         mon_sr = {mon_sr[6:0], spi_miso};
         mon_n++;
         if (mon_n == 8) begin
            mon_n = 0;
            if (exp_byte.size() == 0) unexpected("byte_unexpected", {24'h0, mon_sr});
            else check("miso_byte", {24'h0, mon_sr}, exp_byte.pop_front());
         end
      end
   end

   task automatic xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
      rx = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         spi_clk  = 1'b0;
         spi_mosi = tx[i];
         #HALF;
         rx = {rx[30:0], spi_miso};
         spi_clk = 1'b1;
         #HALF;
      end
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_high();
      #HALF;
      spi_cs_n = 1'b1;
      #(HALF * 2);
   endtask

   task automatic read_frame(input logic [23:0] addr, input int nbytes, output logic [31:0] rx);
      logic [31:0] dummy;
      cs_low();
      xfer(32'h03, 8, dummy);
      xfer({8'h0, addr}, 24, dummy);
      xfer(32'h0, nbytes * 8, rx);
      cs_high();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rx;
      int n;

      #100;
      reset_n = 1'b1;
      #20;
      check("rst_powered_down", {31'h0, powered_down}, 1);
      check("rst_busy",         {31'h0, busy}, 0);
      check("rst_miso",         {31'h0, spi_miso}, 1);
      check("rst_miso_oe",      {31'h0, spi_miso_oe}, 0);
      check("rst_mem_rd_en",    {31'h0, mem_rd_en}, 0);
      check("rst_cmd_opcode",   {24'h0, cmd_opcode}, 0);

      // READ while powered down: opcode reported, nothing else happens.
      exp_cmd.push_back(32'h03);
      read_frame(24'h000010, 2, rx);
      check("pd_read_miso", rx, 32'h0000FFFF);
      check("pd_still_down", {31'h0, powered_down}, 1);

      // Wake-up.
      exp_cmd.push_back(32'hAB);
      exp_busy.push_back(875);
      cs_low();
      xfer(32'hAB, 8, rx);
      spi_cs_n = 1'b1;
      n = 0;
      while (powered_down && n < 8) begin
         @(negedge clock);
         n++;
      end
      check("wake_powered_down", {31'h0, powered_down}, 0);
      check("wake_busy", {31'h0, busy}, 1);
      #(HALF * 2);

      // READ during busy is ignored.
      exp_cmd.push_back(32'h03);
      cs_low();
      xfer(32'h03, 8, rx);
      xfer(32'h000100, 24, rx);
      cs_high();
      check("busy_read_still_busy", {31'h0, busy}, 1);
      check("busy_read_oe", {31'h0, spi_miso_oe}, 0);
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("busy_cleared", {31'h0, busy}, 0);
      #20;

      // READ at 0x000100, three bytes.
      exp_cmd.push_back(32'h03);
      exp_addr.push_back(32'h000100);
      exp_addr.push_back(32'h000101);
      exp_addr.push_back(32'h000102);
      exp_addr.push_back(32'h000103);
      exp_byte.push_back(32'h5A);
      exp_byte.push_back(32'h5B);
      exp_byte.push_back(32'h58);
      read_frame(24'h000100, 3, rx);

      // READ across the top of the address space.
      exp_cmd.push_back(32'h03);
      exp_addr.push_back(32'hFFFFFE);
      exp_addr.push_back(32'hFFFFFF);
      exp_addr.push_back(32'h000000);
      exp_addr.push_back(32'h000001);
      exp_byte.push_back(32'hA4);
      exp_byte.push_back(32'hA5);
      exp_byte.push_back(32'h5A);
      read_frame(24'hFFFFFE, 3, rx);

      // 0x0B is unsupported in the default build.
      exp_cmd.push_back(32'h0B);
      cs_low();
      xfer(32'h0B, 8, rx);
      xfer(32'h000040, 24, rx);
      xfer(32'h0, 8, rx);
      cs_high();
      check("fast_read_ignored_miso", rx, 32'h000000FF);

      // Abort after 12 address bits, then a clean READ.
      exp_cmd.push_back(32'h03);
      cs_low();
      xfer(32'h03, 8, rx);
      xfer(32'h000, 12, rx);
      cs_high();
      check("abort_state_idle", 32'(dut.state), 0);
      check("abort_oe", {31'h0, spi_miso_oe}, 0);

      exp_cmd.push_back(32'h03);
      exp_addr.push_back(32'h000020);
      exp_addr.push_back(32'h000021);
      exp_byte.push_back(32'h7A);
      read_frame(24'h000020, 1, rx);

      // Deep power-down needs exactly 8 bits in the frame.
      exp_cmd.push_back(32'hB9);
      cs_low();
      xfer(32'h172, 9, rx);
      cs_high();
      check("b9_9bit_powered_down", {31'h0, powered_down}, 0);

      exp_cmd.push_back(32'hB9);
      cs_low();
      xfer(32'hB9, 8, rx);
      cs_high();
      check("b9_8bit_powered_down", {31'h0, powered_down}, 1);
      check("last_cmd_opcode", {24'h0, cmd_opcode}, 32'hB9);

      #200;
      check("cmd_queue_empty",  exp_cmd.size(), 0);
      check("addr_queue_empty", exp_addr.size(), 0);
      check("byte_queue_empty", exp_byte.size(), 0);
      check("busy_queue_empty", exp_busy.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
